// File: rtl/counter_pkg.sv
// Shared constants for the counter family (modulo counter, divider,
// sequencer). Direction and mode encodings are single bits so they map
// straight onto the `up` and `sat` control pins.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_step.sv
// Combinational next-value unit for the modulo counter.
// Ports:
//   count  : current count (0..MODULUS-1)
//   up     : direction, DIR_UP increments, DIR_DOWN decrements
//   sat    : MODE_WRAP wraps at the bounds, MODE_SAT holds at the bounds
//   next   : count after one step
//   wrap   : this step wraps past a bound
//   block  : this step is held at a bound in saturate mode
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] next,
  output logic             wrap,
  output logic             block
);

  // One extra bit of headroom so count+1 == MODULUS is visible even when
  // MODULUS == 2**WIDTH; the wrap is decided explicitly, never by overflow.
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] inc_x;
  logic [WIDTH:0] dec_x;

  always_comb begin
    cnt_x = {1'b0, count};
    inc_x = cnt_x + ONE_X;
    dec_x = cnt_x - ONE_X;
    next  = count;
    wrap  = 1'b0;
    block = 1'b0;
    if (up == DIR_UP) begin
      if (inc_x < MOD_X) begin
        next = inc_x[WIDTH-1:0];
      end else if (sat == MODE_SAT) begin
        block = 1'b1;
      end else begin
        next = '0;
        wrap = 1'b1;
      end
    end else begin
      if (cnt_x != '0) begin
        next = dec_x[WIDTH-1:0];
      end else if (sat == MODE_SAT) begin
        block = 1'b1;
      end else begin
        next = MAX_X[WIDTH-1:0];
        wrap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Parametrised synchronous modulo counter with enable, direction, parallel
// load, wrap/saturate mode and status flags.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset (count <= RESET_VALUE)
//   en         : count enable
//   up         : 1 = increment, 0 = decrement
//   sat        : 0 = wrap at bounds, 1 = saturate at bounds
//   load       : parallel load strobe (wins over en)
//   load_value : value to load; out-of-range values load MODULUS-1
//   count      : registered count
//   tc         : combinational terminal count, usable as the next stage's en
//   wrapped    : one-cycle pulse, previous edge wrapped the count
//   sat_hit    : sticky, a step was blocked at a bound (cleared by reset/load)
//   load_err   : one-cycle pulse, previous edge loaded an out-of-range value
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 2 ** WIDTH,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             sat_hit,
  output logic             load_err
);

  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic             step_block;
  logic             load_ok;

  counter_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .count (count),
    .up    (up),
    .sat   (sat),
    .next  (step_next),
    .wrap  (step_wrap),
    .block (step_block)
  );

  assign load_ok = ({1'b0, load_value} < MOD_X);

  // Only en and up reach tc, so cascaded stages stay synchronous.
  assign tc = en & ((up == DIR_UP) ? (count == MAX_V) : (count == '0));

  // Register stage: reset > load > en, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= RST_V;
      wrapped  <= 1'b0;
      sat_hit  <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= load_ok ? load_value : MAX_V;
      wrapped  <= 1'b0;
      sat_hit  <= 1'b0;
      load_err <= ~load_ok;
    end else begin
      wrapped  <= 1'b0;
      load_err <= 1'b0;
      if (en) begin
        count   <= step_next;
        wrapped <= step_wrap;
        if (step_block) begin
          sat_hit <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter (WIDTH=3, MODULUS=6, RESET_VALUE=0).
// Each stimulus cycle pushes the hand-computed state expected to be visible
// during that cycle; a monitor pops and compares on the falling edge.
module tb_mod_counter;

  logic       clock;
  logic       reset, load, en, up, sat;
  logic [2:0] load_value;
  logic [2:0] count;
  logic       tc, wrapped, sat_hit, load_err;

  // cascade pair
  logic       creset, cen;
  logic [2:0] c0_count, c1_count;
  logic       c0_tc, c1_tc, c0_w, c1_w, c0_sh, c1_sh, c0_le, c1_le;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;   // 0 = main counter, 1 = cascade pair
    logic [2:0] c;
    logic       t, w, sh, le;
    logic [2:0] c1;
  } exp_t;

  exp_t sbq[$];

  mod_counter #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(0)) dut (
    .clock(clock), .reset(reset), .en(en), .up(up), .sat(sat),
    .load(load), .load_value(load_value), .count(count), .tc(tc),
    .wrapped(wrapped), .sat_hit(sat_hit), .load_err(load_err)
  );

  mod_counter #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(0)) u_c0 (
    .clock(clock), .reset(creset), .en(cen), .up(1'b1), .sat(1'b0),
    .load(1'b0), .load_value(3'd0), .count(c0_count), .tc(c0_tc),
    .wrapped(c0_w), .sat_hit(c0_sh), .load_err(c0_le)
  );

  mod_counter #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(0)) u_c1 (
    .clock(clock), .reset(creset), .en(c0_tc), .up(1'b1), .sat(1'b0),
    .load(1'b0), .load_value(3'd0), .count(c1_count), .tc(c1_tc),
    .wrapped(c1_w), .sat_hit(c1_sh), .load_err(c1_le)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.kind == 0) begin
        chk("count",    {5'd0, count},    {5'd0, e.c});
        chk("tc",       {7'd0, tc},       {7'd0, e.t});
        chk("wrapped",  {7'd0, wrapped},  {7'd0, e.w});
        chk("sat_hit",  {7'd0, sat_hit},  {7'd0, e.sh});
        chk("load_err", {7'd0, load_err}, {7'd0, e.le});
      end else begin
        chk("cas_c0", {5'd0, c0_count}, {5'd0, e.c});
        chk("cas_c1", {5'd0, c1_count}, {5'd0, e.c1});
        chk("cas_tc0", {7'd0, c0_tc},   {7'd0, e.t});
      end
    end
  end

  // Drive inputs for this cycle and queue what should be seen during it.
  task automatic step(input logic r, l, input logic [2:0] lv, input logic e, u, s,
                      input logic [2:0] ec, input logic et, ew, esh, ele);
    exp_t x;
    reset = r; load = l; load_value = lv; en = e; up = u; sat = s;
    x.kind = 0; x.c = ec; x.t = et; x.w = ew; x.sh = esh; x.le = ele; x.c1 = 3'd0;
    sbq.push_back(x);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; load = 1'b0; load_value = 3'd0; en = 1'b0; up = 1'b0; sat = 1'b0;
    creset = 1'b1; cen = 1'b0;
    @(posedge clock);
    #1;

    //     r  l  lv    e  u  s     cnt   tc w  sh le
    // up count with wrap
    step(0, 0, 3'd0, 1, 1, 0,   3'd0, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 0,   3'd1, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 0,   3'd2, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 0,   3'd3, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 0,   3'd4, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 0,   3'd5, 1, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 0,   3'd0, 0, 1, 0, 0);
    step(0, 0, 3'd0, 1, 1, 0,   3'd1, 0, 0, 0, 0);
    // load 2, then count down with wrap
    step(0, 1, 3'd2, 0, 0, 0,   3'd2, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0,   3'd2, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0,   3'd1, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0,   3'd0, 1, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 0,   3'd5, 0, 1, 0, 0);
    // load 3, then count up in saturate mode
    step(0, 1, 3'd3, 0, 0, 0,   3'd4, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 1,   3'd3, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 1,   3'd4, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 1,   3'd5, 1, 0, 0, 0);
    step(0, 0, 3'd0, 1, 1, 1,   3'd5, 1, 0, 1, 0);
    step(0, 0, 3'd0, 1, 1, 1,   3'd5, 1, 0, 1, 0);
    // load 1 clears sat_hit; out-of-range load; in-range load
    step(0, 1, 3'd1, 0, 0, 0,   3'd5, 0, 0, 1, 0);
    step(0, 1, 3'd7, 0, 0, 0,   3'd1, 0, 0, 0, 0);
    step(0, 1, 3'd4, 0, 0, 0,   3'd5, 0, 0, 0, 1);
    // load 0, then saturate downward
    step(0, 1, 3'd0, 0, 0, 0,   3'd4, 0, 0, 0, 0);
    step(0, 0, 3'd0, 1, 0, 1,   3'd0, 1, 0, 0, 0);
    // reset with coincident load and en wins
    step(1, 1, 3'd3, 1, 1, 0,   3'd0, 0, 0, 1, 0);
    // load with en: loaded value, no step
    step(0, 1, 3'd3, 1, 1, 0,   3'd0, 0, 0, 0, 0);
    step(0, 0, 3'd0, 0, 0, 0,   3'd3, 0, 0, 0, 0);
    step(0, 0, 3'd0, 0, 0, 0,   3'd3, 0, 0, 0, 0);

    // cascade: stage 1 enabled by stage 0 tc
    creset = 1'b1; cen = 1'b0;
    @(posedge clock);
    #1;
    creset = 1'b0;
    for (int i = 0; i <= 36; i++) begin
      exp_t x;
      cen = 1'b1;
      x.kind = 1;
      x.c  = 3'((i % 6));
      x.c1 = 3'(((i / 6) % 6));
      x.t  = ((i % 6) == 5);
      x.w = 1'b0; x.sh = 1'b0; x.le = 1'b0;
      sbq.push_back(x);
      @(posedge clock);
      #1;
    end
    cen = 1'b0;

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clock);
    #1;
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous modulo counter, successor to the three-stage ripple counter. All bits change on the same `clock` edge, so the ripple skew between stages is gone. Adds:
- synchronous reset
- count enable and up/down direction
- parallel load
- wrap or saturate mode
- terminal-count and wrap/saturate status outputs

Used as the general-purpose counter for dividers, sequencers and the binary-to-decimal display path (`count` feeds a `number` display).

## Interface
Parameters:
- `WIDTH`, 3: counter width in bits; ≥1.
- `MODULUS`, 2**WIDTH: count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2**WIDTH.
- `RESET_VALUE`, 0: value loaded by reset; must be < MODULUS.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `sat`  in  1  mode: 0 = wrap at bounds, 1 = saturate at bounds.
- `load`  in  1  parallel load strobe.
- `load_value`  in  WIDTH  value to load.
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count, combinational:
  - `en & up & (count==MODULUS-1)`, or
  - `en & ~up & (count==0)`.
- `wrapped`  out  1  registered one-cycle pulse: the previous edge wrapped the count.
- `sat_hit`  out  1  sticky, registered: a count was blocked at a bound in saturate mode.
- `load_err`  out  1  registered one-cycle pulse: the previous edge loaded an out-of-range value.

## Operation
- Priority at each rising edge: `reset` > `load` > `en`. With none of them asserted, `count` holds.
- Reset:
  - `count`=RESET_VALUE
  - `wrapped`=0, `sat_hit`=0, `load_err`=0
- Load:
  - If `load_value` < MODULUS: `count`=`load_value` and `load_err`=0.
  - Otherwise: `count`=MODULUS-1 and `load_err`=1.
  - Load clears `sat_hit` and forces `wrapped`=0.
  - `en`, `up` and `sat` are ignored in a load cycle.
- Count, with `en`=1 and `load`=0:
  - `up`=1, `count`<MODULUS-1: `count`+1.
  - `up`=1, `count`=MODULUS-1, `sat`=0: `count`=0 and `wrapped`=1.
  - `up`=1, `count`=MODULUS-1, `sat`=1: hold and set `sat_hit`.
  - `up`=0, `count`>0: `count`-1.
  - `up`=0, `count`=0, `sat`=0: `count`=MODULUS-1 and `wrapped`=1.
  - `up`=0, `count`=0, `sat`=1: hold and set `sat_hit`.
- Arithmetic: next value is computed at WIDTH+1 bits and compared against MODULUS. When MODULUS=2**WIDTH there is no truncation artefact; wrap is explicit, not overflow-based.
- `wrapped` and `load_err` are 0 on every edge that did not cause them.
- `sat_hit` stays 1 until reset or load.
- `up`, `sat` and `en` may change every cycle; only their values at the edge matter.
- Reset asserted mid-count or coincident with `load` wins unconditionally.

## Timing
- Latency is one cycle: the `count` change is visible after the edge where `en` or `load` was sampled.
- `tc` is combinational, valid in the same cycle as the `count` and `en`/`up` it depends on. This lets cascaded counters use `tc` as the next stage's `en`, giving synchronous cascading with no clock derived from data.
- `wrapped` and `load_err` go high in the same cycle the new `count` is visible, for exactly one cycle.
- No combinational path from `load_value`, `sat` or `load` to any output; only `en` and `up` reach `tc`.
- The full count range is reachable at one step per clock. Period is MODULUS cycles in wrap mode.

## Structure
- `counter_pkg`: direction constants `DIR_UP`/`DIR_DOWN` and mode constants `MODE_WRAP`/`MODE_SAT`, shared with the divider and sequencer blocks.
- One sub-module, `counter_step`: combinational next-value unit.
  - Inputs: `count`, `up`, `sat`.
  - Outputs: next count, wrap flag, saturate-block flag.
- `mod_counter` holds the registers, load range check and priority logic.

## Test plan
WIDTH=3, MODULUS=6, RESET_VALUE=0 unless stated.
- Reset, then `en`=1, `up`=1, `sat`=0 for 8 cycles:
  - `count` = 1,2,3,4,5,0,1,2.
  - `tc`=1 while `count`=5.
  - `wrapped`=1 only in the cycle `count` returns to 0.
- Load 2, then `up`=0 for 4 cycles:
  - `count` = 1,0,5,4.
  - `tc`=1 while `count`=0.
  - `wrapped` pulses once, at the 0→5 step.
- `sat`=1, `up`=1, count from 3 for 5 cycles:
  - `count` = 4,5,5,5,5.
  - `sat_hit` rises after the first blocked edge and stays 1.
  - A subsequent load of 1 clears `sat_hit` and sets `count`=1.
- Load `load_value`=7 (≥ MODULUS):
  - `count`=5, `load_err`=1 for one cycle.
  - Load 4 the next cycle: `count`=4, `load_err`=0.
- `reset`, `load`=1 (`load_value`=3) and `en`=1 asserted together:
  - `count`=0 and all flags 0.
  - Then `load` with `en`=1: `count`=3, with no count step in that cycle.
- Two instances cascaded, stage 1 `en` = stage 0 `tc`, both MODULUS=6, wrap, `up`, `en0`=1 for 36 cycles:
  - Stage 1 steps exactly once per 6 cycles.
  - Both return to 0 together at cycle 36.
